dm_responder: RTL and testbench

- Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake and returns a response after a programmable latency.
- Sits between the pipeline's MEM stage and the word-organised data SRAM. It replaces the zero-latency combinational DM, so stall/backpressure paths can be exercised.
- Also emits a one-cycle write-trace record (PC, address, data) for every committed store, for the grading log.

---
 rtl/dm_responder_if.sv | 31 +++
 rtl/dm_responder.sv | 148 ++++++++++++++
 tb/tb_dm_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Data-memory request/response bus between the core (master) and the
// latency-programmable responder (slave), plus the store write-trace.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wr_trace_valid;
    logic [31:0] wr_trace_pc;
    logic [31:0] wr_trace_addr;
    logic [31:0] wr_trace_data;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  wr_trace_valid, wr_trace_pc, wr_trace_addr, wr_trace_data
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output wr_trace_valid, wr_trace_pc, wr_trace_addr, wr_trace_data
    );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data memory answering one load/store at a time after a fixed
// programmable latency, with a one-cycle trace record for each committed store.
module dm_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 3
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tpc_q, tpc_d;
    logic [31:0] taddr_q, taddr_d;
    logic [31:0] tdata_q, tdata_d;

    logic [31:0]       mem_q [Depth];
    logic [ADDR_W-1:0] widx;
    logic              in_range;
    logic              mem_we;
    logic [31:0]       old_word;
    logic [31:0]       merged;

    assign widx     = addr_q[ADDR_W+1:2];
    assign in_range = (addr_q[31:ADDR_W+2] == '0);
    assign old_word = mem_q[widx];

    // For loads (and be = 0 stores) the merged word is simply the old word.
    always_comb begin
        merged = old_word;
        if (we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pc_d     = pc_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tvalid_d = 1'b0;
        tpc_d    = tpc_q;
        taddr_d  = taddr_q;
        tdata_d  = tdata_q;
        mem_we   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    be_d    = bus.req_be;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    count_d = 4'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    state_d = StResp;
                    err_d   = ~in_range;
                    rdata_d = in_range ? merged : 32'h0;
                    if (we_q && in_range && (be_q != 4'h0)) begin
                        mem_we   = 1'b1;
                        tvalid_d = 1'b1;
                        tpc_d    = pc_q;
                        taddr_d  = {addr_q[31:2], 2'b00};
                        tdata_d  = merged;
                    end
                end
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= 4'd0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            pc_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tpc_q    <= 32'h0;
            taddr_q  <= 32'h0;
            tdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pc_q     <= pc_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tvalid_q <= tvalid_d;
            tpc_q    <= tpc_d;
            taddr_q  <= taddr_d;
            tdata_q  <= tdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= 32'h0;
        end else if (mem_we) begin
            mem_q[widx] <= merged;
        end
    end

    assign bus.req_ready      = (state_q == StIdle);
    assign bus.resp_valid     = (state_q == StResp);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;
    assign bus.wr_trace_valid = tvalid_q;
    assign bus.wr_trace_pc    = tpc_q;
    assign bus.wr_trace_addr  = taddr_q;
    assign bus.wr_trace_data  = tdata_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=3 instance for most scenarios and
// a LATENCY=1 instance for the minimum-latency and be=0 store cases.
module tb_dm_responder;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dm_responder_if bus3 ();
    dm_responder_if bus1 ();

    dm_responder #(.ADDR_W(12), .LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));
    dm_responder #(.ADDR_W(12), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int          trace3_cnt = 0;
    int          trace1_cnt = 0;
    logic [95:0] trace3_q[$];

    always @(negedge clk) begin
        if (bus3.wr_trace_valid === 1'b1) begin
            trace3_q.push_back({bus3.wr_trace_pc, bus3.wr_trace_addr, bus3.wr_trace_data});
            trace3_cnt++;
        end
        if (bus1.wr_trace_valid === 1'b1) trace1_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Entered at posedge+1 with the DUT idle; returns at posedge+1 after handshake.
    task automatic issue3(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc, output int lat,
                          output logic rdy_after, output logic [31:0] rdata, output logic err);
        bus3.req_valid = 1'b1; bus3.req_we = we; bus3.req_be = be;
        bus3.req_addr = addr; bus3.req_wdata = wdata; bus3.req_pc = pc;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        rdy_after = bus3.req_ready;
        lat = 0;
        while (bus3.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus3.resp_rdata;
        err   = bus3.resp_err;
        bus3.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.resp_ready = 1'b0;
    endtask

    task automatic issue1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
        bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_be = be;
        bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_pc = 32'h5000;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        lat = 0;
        while (bus1.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus1.resp_rdata;
        bus1.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus1.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus3.req_ready !== 1'b1) begin bad++;
            $display("FAIL reset_req_ready: got %b want 1", bus3.req_ready); end
        total++; if (bus3.resp_valid !== 1'b0) begin bad++;
            $display("FAIL reset_resp_valid: got %b want 0", bus3.resp_valid); end
        total++; if (bus3.resp_err !== 1'b0) begin bad++;
            $display("FAIL reset_resp_err: got %b want 0", bus3.resp_err); end
        total++; if (bus3.resp_rdata !== 32'h0) begin bad++;
            $display("FAIL reset_resp_rdata: got %h want 0", bus3.resp_rdata); end
        total++; if (bus3.wr_trace_valid !== 1'b0) begin bad++;
            $display("FAIL reset_trace_valid: got %b want 0", bus3.wr_trace_valid); end
        total++;
        if ({bus3.wr_trace_pc, bus3.wr_trace_addr, bus3.wr_trace_data} !== 96'h0) begin bad++;
            $display("FAIL reset_trace_bus: got %h %h %h want 0", bus3.wr_trace_pc,
                     bus3.wr_trace_addr, bus3.wr_trace_data); end
        total++; if (bus1.req_ready !== 1'b1) begin bad++;
            $display("FAIL reset_req_ready_l1: got %b want 1", bus1.req_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_latency();
        int lat; logic rdy; logic [31:0] rd; logic err;
        issue3(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h1000, lat, rdy, rd, err);
        total++; if (rdy !== 1'b0) begin bad++;
            $display("FAIL load_ready_drop: got %b want 0", rdy); end
        total++; if (lat != 3) begin bad++;
            $display("FAIL load_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL load_rdata: got %h want 00000000", rd); end
        total++; if (err !== 1'b0) begin bad++;
            $display("FAIL load_err: got %b want 0", err); end
    endtask

    task automatic test_store_merge();
        int lat; logic rdy; logic [31:0] rd; logic err; int n0;
        n0 = trace3_cnt;
        issue3(1'b1, 4'hF, 32'h20, 32'h1234_5678, 32'h3004, lat, rdy, rd, err);
        total++; if (rd !== 32'h1234_5678) begin bad++;
            $display("FAIL store_full_rdata: got %h want 12345678", rd); end
        issue3(1'b1, 4'b0100, 32'h22, 32'h00AB_0000, 32'h3008, lat, rdy, rd, err);
        total++; if (rd !== 32'h12AB_5678) begin bad++;
            $display("FAIL store_byte_rdata: got %h want 12ab5678", rd); end
        total++; if (trace3_cnt != n0 + 2) begin bad++;
            $display("FAIL store_trace_count: got %0d want %0d", trace3_cnt - n0, 2); end
        total++;
        if (trace3_q[n0] !== {32'h3004, 32'h20, 32'h1234_5678}) begin bad++;
            $display("FAIL store_trace0: got %h want 00003004_00000020_12345678", trace3_q[n0]); end
        total++;
        if (trace3_q[n0+1] !== {32'h3008, 32'h20, 32'h12AB_5678}) begin bad++;
            $display("FAIL store_trace1: got %h want 00003008_00000020_12ab5678",
                     trace3_q[n0+1]); end
        issue3(1'b0, 4'h0, 32'h20, 32'h0, 32'h300C, lat, rdy, rd, err);
        total++; if (rd !== 32'h12AB_5678) begin bad++;
            $display("FAIL store_readback: got %h want 12ab5678", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_be = 4'hF;
        bus3.req_addr = 32'h20; bus3.req_wdata = 32'h0; bus3.req_pc = 32'h3010;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        // Scribble over the request fields; the captured copy must win.
        bus3.req_we = 1'b1; bus3.req_addr = 32'h24; bus3.req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        while (bus3.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++; if (lat != 3) begin bad++;
            $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus3.resp_valid !== 1'b1) begin bad++;
                $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, bus3.resp_valid); end
            total++; if (bus3.resp_rdata !== 32'h12AB_5678) begin bad++;
                $display("FAIL bp_rdata_hold[%0d]: got %h want 12ab5678", i, bus3.resp_rdata); end
            total++; if (bus3.req_ready !== 1'b0) begin bad++;
                $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus3.req_ready); end
            @(posedge clk); #1;
        end
        bus3.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.resp_ready = 1'b0;
        bus3.req_we = 1'b0;
        total++; if (bus3.resp_valid !== 1'b0) begin bad++;
            $display("FAIL bp_release_valid: got %b want 0", bus3.resp_valid); end
        total++; if (bus3.req_ready !== 1'b1) begin bad++;
            $display("FAIL bp_release_ready: got %b want 1", bus3.req_ready); end
    endtask

    task automatic test_out_of_range();
        int lat; logic rdy; logic [31:0] rd; logic err; int n0;
        n0 = trace3_cnt;
        issue3(1'b1, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF, 32'h4000, lat, rdy, rd, err);
        total++; if (err !== 1'b1) begin bad++;
            $display("FAIL oor_err: got %b want 1", err); end
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL oor_rdata: got %h want 00000000", rd); end
        total++; if (trace3_cnt != n0) begin bad++;
            $display("FAIL oor_no_trace: got %0d pulses want 0", trace3_cnt - n0); end
        issue3(1'b0, 4'hF, 32'h0, 32'h0, 32'h4004, lat, rdy, rd, err);
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL oor_alias_rdata: got %h want 00000000", rd); end
        total++; if (err !== 1'b0) begin bad++;
            $display("FAIL oor_alias_err: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_busy();
        int lat; logic rdy; logic [31:0] rd; logic err; int n0;
        n0 = trace3_cnt;
        bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.req_be = 4'hF;
        bus3.req_addr = 32'h40; bus3.req_wdata = 32'hCAFE_F00D; bus3.req_pc = 32'h6000;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        total++; if (bus3.resp_valid !== 1'b0) begin bad++;
            $display("FAIL rst_busy_valid: got %b want 0", bus3.resp_valid); end
        total++; if (bus3.req_ready !== 1'b1) begin bad++;
            $display("FAIL rst_busy_ready: got %b want 1", bus3.req_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (trace3_cnt != n0) begin bad++;
            $display("FAIL rst_busy_no_trace: got %0d pulses want 0", trace3_cnt - n0); end
        issue3(1'b0, 4'hF, 32'h40, 32'h0, 32'h6004, lat, rdy, rd, err);
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL rst_busy_load40: got %h want 00000000", rd); end
        issue3(1'b0, 4'hF, 32'h20, 32'h0, 32'h6008, lat, rdy, rd, err);
        total++; if (rd !== 32'h0) begin bad++;
            $display("FAIL rst_mem_cleared: got %h want 00000000", rd); end
    endtask

    task automatic test_latency1();
        int lat; logic [31:0] rd; int n0;
        issue1(1'b0, 4'hF, 32'h8, 32'h0, lat, rd);
        total++; if (lat != 1) begin bad++;
            $display("FAIL l1_latency: got %0d want 1", lat); end
        n0 = trace1_cnt;
        issue1(1'b1, 4'hF, 32'h8, 32'h1122_3344, lat, rd);
        total++; if (trace1_cnt != n0 + 1) begin bad++;
            $display("FAIL l1_store_trace: got %0d pulses want 1", trace1_cnt - n0); end
        n0 = trace1_cnt;
        issue1(1'b1, 4'h0, 32'h8, 32'hFFFF_FFFF, lat, rd);
        total++; if (rd !== 32'h1122_3344) begin bad++;
            $display("FAIL l1_be0_rdata: got %h want 11223344", rd); end
        total++; if (trace1_cnt != n0) begin bad++;
            $display("FAIL l1_be0_no_trace: got %0d pulses want 0", trace1_cnt - n0); end
        issue1(1'b0, 4'hF, 32'h8, 32'h0, lat, rd);
        total++; if (rd !== 32'h1122_3344) begin bad++;
            $display("FAIL l1_readback: got %h want 11223344", rd); end
    endtask

    initial begin
        reset = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_be = 4'h0;
        bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0; bus3.req_pc = 32'h0;
        bus3.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_be = 4'h0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0; bus1.req_pc = 32'h0;
        bus1.resp_ready = 1'b0;
        #1;
        test_reset();
        test_load_latency();
        test_store_merge();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_busy();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
